// File: rtl/mux8_arb_pkg.sv
// Shared constants, FSM state encoding and the round-robin winner search
// for the 8-channel mux arbiter.
package mux8_arb_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        GNT  = 1'b1
    } state_e;

    // Search starts just after ptr and wraps; ptr itself is searched last.
    function automatic logic [SEL_W-1:0] rr_next(
        input logic [SEL_W-1:0]  ptr,
        input logic [NUM_CH-1:0] req
    );
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_next = ptr;
        found   = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux8_w.sv
// DATA_W-wide 8:1 multiplexer; channel i occupies bits [i*DATA_W +: DATA_W].
module mux8_w
    import mux8_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [NUM_CH*DATA_W-1:0] in,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                out = in[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 data mux among 8 requesters and streaming
// beats to a single valid/ready sink. Optional grant statistics: MUX8_ARB_STATS_EN.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        last,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic [NUM_CH-1:0]        ack,
    output logic                     busy
`ifdef MUX8_ARB_STATS_EN
    ,
    output logic [15:0]              grant_cnt,
    output logic                     stall
`endif
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [7:0]       cnt_q,   cnt_d;
    logic [7:0]       cnt_inc;
    logic             accept;
    logic [DATA_W-1:0] mux_out;

    assign cnt_inc = cnt_q + 8'd1;
    assign out_sel = sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(NUM_CH - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GNT;
                    sel_d   = rr_next(ptr_q, req);
                    ptr_d   = sel_d;
                    cnt_d   = '0;
                end
            end
            GNT: begin
                // A withdrawn channel gives up the grant without a beat.
                if (!req[sel_q]) begin
                    state_d = IDLE;
                end else if (accept) begin
                    cnt_d = cnt_inc;
                    if (last[sel_q] || (cnt_inc == HOLD_LIM)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        accept    = 1'b0;
        ack       = '0;
        busy      = 1'b0;
        if (state_q == GNT) begin
            busy      = 1'b1;
            out_valid = req[sel_q];
            accept    = out_valid && out_ready;
            if (accept) begin
                ack = NUM_CH'(1) << sel_q;
            end
        end
    end

    mux8_w #(
        .DATA_W (DATA_W)
    ) u_mux (
        .in  (in_data),
        .sel (sel_q),
        .out (mux_out)
    );

    assign out_data = out_valid ? mux_out : '0;

`ifdef MUX8_ARB_STATS_EN
    logic [15:0] grant_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
        end else if ((state_q == IDLE) && (|req) && (grant_cnt_q != 16'hFFFF)) begin
            grant_cnt_q <= grant_cnt_q + 16'd1;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall     = out_valid & ~out_ready;
`endif

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 8:1 data mux between 8 requesters. It picks one requesting channel, holds that channel's select on the mux, and streams beats to a single downstream valid/ready sink. The grant is released on the channel's last beat, on a hold limit, or when the channel withdraws. It sits between 8 producer channels and one shared consumer port.

Parameters:
- DATA_W, 8: width of each channel's data and of out_data.
- MAX_HOLD, 4: maximum beats accepted per grant before forced re-arbitration; legal range 1..255.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 8: per-channel request; bit i high means channel i has a beat on in_data.
- last, input, 8: per-channel final-beat flag; sampled only for the granted channel.
- in_data, input, 8*DATA_W: channel i's data is bits [i*DATA_W +: DATA_W].
- out_valid, output, 1: beat available to the sink.
- out_ready, input, 1: sink accepts the beat.
- out_data, output, DATA_W: selected channel data.
- out_sel, output, 3: registered select of the granted channel; also drives the shared mux.
- ack, output, 8: one-hot, combinational; ack[i] is high in the cycle a beat from channel i is accepted.
- busy, output, 1: high while in GNT.

Behaviour:
- Reset (async, rst_n low): state=IDLE, out_sel=0, rr_ptr=7 so channel 0 has top priority first, beat_cnt=0, busy=0. out_valid, ack and out_data are 0 while in reset.
- FSM states: IDLE and GNT.
- IDLE:
  - If req is 0, stay in IDLE.
  - Otherwise, winner = first set bit of req searching (rr_ptr+1), (rr_ptr+2), ... modulo 8.
  - Next edge: out_sel<=winner, rr_ptr<=winner, beat_cnt<=0, state<=GNT.
  - Arbitration latency is 1 cycle. There is always exactly one IDLE bubble between grants.
- GNT:
  - out_valid = req[out_sel].
  - out_data = in_data slice at out_sel when out_valid, else 0.
  - A beat is accepted when out_valid and out_ready are both high. In that cycle ack[out_sel]=1 and beat_cnt increments.
- Release (to IDLE on the next edge) when either:
  - an accepted beat has last[out_sel]=1, or
  - an accepted beat brings beat_cnt to MAX_HOLD.
  - If both occur together, it is one release.
- Withdrawal: if req[out_sel]=0 while in GNT, release to IDLE on the next edge with no beat and no ack.
- out_ready high with out_valid low has no effect.
- Requests on other channels never pre-empt a grant.
- beat_cnt width is 8 bits and never exceeds MAX_HOLD.
- If a channel's req stays high after release, that channel is eligible again, but is searched last (rr_ptr = that channel).
- out_sel holds its value in IDLE; it is not cleared.
- Reset asserted mid-grant aborts immediately: no ack, state=IDLE. After reset, priority restarts at channel 0.

Optional Feature:
- Macro: MUX8_ARB_STATS_EN.
- Defined:
  - Adds output port grant_cnt[15:0], a count of grants issued (IDLE->GNT transitions).
  - The count saturates at 16'hFFFF and resets to 0.
  - Adds output port stall, 1 bit: out_valid & ~out_ready.
- Undefined: neither port exists and no counter logic is built. Core behaviour is identical in both cases.

Decomposition:
- Package mux8_arb_pkg holds:
  - NUM_CH=8 and SEL_W=3;
  - the state encoding (IDLE=1'b0, GNT=1'b1);
  - the round-robin next-winner function.
- One sub-module: mux8_w, a parameterized DATA_W-wide 8:1 mux (in, sel, out). It is instantiated once for out_data; out_data is gated to 0 when out_valid is low.

Test Plan:
- Single requester: after reset, req=8'h04 held, last asserted on the 2nd beat, out_ready=1.
  - Cycle 1: IDLE.
  - Then out_sel=2 and 2 accepted beats with ack=8'h04.
  - Then IDLE, then re-grant of channel 2.
- Round-robin fairness: req=8'hFF constant, last=8'hFF, out_ready=1.
  - Grants occur in order 0,1,2,...,7,0.
  - Exactly one beat per grant, with an IDLE cycle between grants.
- Hold limit: req=8'h01 with last=0 and MAX_HOLD=4.
  - Exactly 4 acks, then IDLE.
  - Then re-grant of channel 0 only if no other req; with req=8'h03 the next grant goes to channel 1.
- Backpressure: grant channel 5, out_ready=0 for 3 cycles.
  - out_valid=1 and out_data = channel 5 data held stable.
  - ack=0 and beat_cnt unchanged.
  - When out_ready rises, 1 ack.
- Withdrawal and reset: while channel 3 is granted, drop req[3] with no beat accepted -> IDLE next cycle, no ack.
  - Then assert rst_n=0 mid-grant of channel 6 -> out_valid=0 immediately.
  - After release with req=8'hFF, the first grant is channel 0.
- With MUX8_ARB_STATS_EN defined: after the fairness run of 9 grants, grant_cnt=9.
  - stall is high exactly during the backpressure cycles.
